post_mac_pipe: RTL and testbench

POST_MAC_PIPE -- requirements
Module: post_mac_pipe

---
 rtl/post_mac_pipe.sv | 121 ++++++++++++
 tb/tb_post_mac_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/post_mac_pipe.sv
// Post-MAC pipeline: bias add / channel sum, then ReLU, arithmetic shift and saturation to OUT_W.
// Latency 2 cycles; both stages stall together when out_valid is held by out_ready=0.
module post_mac_pipe #(
  parameter int NCH   = 6,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            layer,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*IN_W-1:0]   mac_in,
  input  logic [NCH*IN_W-1:0]   bias_in,
  input  logic [IN_W-1:0]       sum_bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*OUT_W-1:0]  out_data,
  output logic [OUT_W-1:0]      out_sum,
  output logic                  out_sat,
  output logic                  mode_err
);

  // One common width wide enough for both the per-channel sum (IN_W+1) and the channel total.
  localparam int SW = IN_W + $clog2(NCH + 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [1:0] L_CONV1 = 2'b00;
  localparam logic [1:0] L_CONV2 = 2'b01;
  localparam logic [1:0] L_FC    = 2'b10;
  localparam logic [1:0] L_RSVD  = 2'b11;

  function automatic logic signed [SW-1:0] sext(input logic [IN_W-1:0] x);
    return {{(SW-IN_W){x[IN_W-1]}}, x};
  endfunction

  // Returns {clamped, value}; >>> floors toward minus infinity.
  function automatic logic [OUT_W:0] narrow(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] sh;
    sh = x >>> SHIFT;
    if (sh > MAXV)      return {1'b1, MAXV[OUT_W-1:0]};
    else if (sh < MINV) return {1'b1, MINV[OUT_W-1:0]};
    else                return {1'b0, sh[OUT_W-1:0]};
  endfunction

  logic                  adv;
  logic                  s1_valid;
  logic [1:0]            s1_layer;
  logic signed [SW-1:0]  s1_val [NCH];
  logic signed [SW-1:0]  s1_sum;
  logic signed [SW-1:0]  val_nxt [NCH];
  logic signed [SW-1:0]  sum_nxt;
  logic [NCH*OUT_W-1:0]  data_nxt;
  logic [OUT_W-1:0]      osum_nxt;
  logic                  sat_nxt;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // FC beats carry the raw MAC value so S2 can treat every channel uniformly.
  always_comb begin
    sum_nxt = sext(sum_bias);
    for (int i = 0; i < NCH; i++) begin
      val_nxt[i] = sext(mac_in[i*IN_W +: IN_W]);
      sum_nxt    = sum_nxt + val_nxt[i];
      if (layer != L_FC)
        val_nxt[i] = val_nxt[i] + sext(bias_in[i*IN_W +: IN_W]);
    end
  end

  always_comb begin
    logic signed [SW-1:0] v;
    logic [OUT_W:0]       r;
    data_nxt = '0;
    osum_nxt = '0;
    sat_nxt  = 1'b0;
    v        = '0;
    r        = '0;
    if (s1_layer == L_CONV1 || s1_layer == L_FC) begin
      for (int i = 0; i < NCH; i++) begin
        v = s1_val[i];
        if (s1_layer == L_CONV1 && v[SW-1]) v = '0;
        r = narrow(v);
        data_nxt[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
        sat_nxt = sat_nxt | r[OUT_W];
      end
    end else if (s1_layer == L_CONV2) begin
      v = s1_sum[SW-1] ? '0 : s1_sum;
      r = narrow(v);
      osum_nxt = r[OUT_W-1:0];
      sat_nxt  = r[OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid  <= in_valid;
        s1_layer  <= layer;
        s1_val    <= val_nxt;
        s1_sum    <= sum_nxt;
        out_valid <= s1_valid;
        out_data  <= data_nxt;
        out_sum   <= osum_nxt;
        out_sat   <= sat_nxt;
      end
      if (adv && in_valid && layer == L_RSVD)
        mode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_post_mac_pipe.sv
// Directed bench for post_mac_pipe: hand-computed vectors for each mode, boundaries,
// backpressure, reserved mode and mid-stream reset.
module tb_post_mac_pipe;
  localparam int NCH = 6, IN_W = 32, OUT_W = 16, SHIFT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, in_valid, in_ready, out_valid, out_ready, out_sat, mode_err;
  logic [1:0]           layer;
  logic [NCH*IN_W-1:0]  mac_in, bias_in;
  logic [IN_W-1:0]      sum_bias;
  logic [NCH*OUT_W-1:0] out_data;
  logic [OUT_W-1:0]     out_sum;

  post_mac_pipe #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .layer(layer), .in_valid(in_valid), .in_ready(in_ready),
    .mac_in(mac_in), .bias_in(bias_in), .sum_bias(sum_bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sum(out_sum), .out_sat(out_sat),
    .mode_err(mode_err)
  );

  // Channel 0, channel 1, and a shared value for channels 2..NCH-1.
  typedef struct {
    logic               vld;
    logic [1:0]         l;
    logic signed [31:0] m0, m1, mr, b0, b1, br, sb;
    logic [15:0]        d0, d1, dr, s;
    logic               sat;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*IN_W-1:0] pk_in(input logic [31:0] a0, a1, ar);
    logic [NCH*IN_W-1:0] p;
    for (int i = 0; i < NCH; i++) p[i*IN_W +: IN_W] = (i == 0) ? a0 : (i == 1) ? a1 : ar;
    return p;
  endfunction

  function automatic logic [NCH*OUT_W-1:0] pk_out(input logic [15:0] a0, a1, ar);
    logic [NCH*OUT_W-1:0] p;
    for (int i = 0; i < NCH; i++) p[i*OUT_W +: OUT_W] = (i == 0) ? a0 : (i == 1) ? a1 : ar;
    return p;
  endfunction

  function automatic vec_t mk(input logic [1:0] l, input logic signed [31:0] m0, m1, mr, b0, b1, br, sb,
                              input logic [15:0] d0, d1, dr, s, input logic sat);
    vec_t v;
    v.vld = 1'b1; v.l = l; v.m0 = m0; v.m1 = m1; v.mr = mr; v.b0 = b0; v.b1 = b1; v.br = br; v.sb = sb;
    v.d0 = d0; v.d1 = d1; v.dr = dr; v.s = s; v.sat = sat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.vld;
    layer    = v.l;
    mac_in   = pk_in(v.m0, v.m1, v.mr);
    bias_in  = pk_in(v.b0, v.b1, v.br);
    sum_bias = v.sb;
  endtask

  task automatic expect_out(input string tag, input vec_t v);
    chk({tag, "_valid"}, out_valid, v.vld);
    if (v.vld) begin
      chk({tag, "_data"}, out_data, pk_out(v.d0, v.d1, v.dr));
      chk({tag, "_sum"}, out_sum, v.s);
      chk({tag, "_sat"}, out_sat, v.sat);
    end
  endtask

  vec_t tbl [12];
  vec_t bub, va, vb, vc, vr;

  initial begin
    // 0: conv1 basic; 1: conv2 basic (per-channel biases ignored); 2: FC with clamp (biases ignored)
    tbl[0]  = mk(2'b00, 32'sh50, -32'sd100, 0, 32'sh08, 0, 0, 0, 16'h000B, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tbl[1]  = mk(2'b01, 1000, 1000, 1000, 500, 500, 500, -32'sd40, 16'h0000, 16'h0000, 16'h0000, 16'h02E9, 1'b0);
    tbl[2]  = mk(2'b10, -32'sd64, 32'sh7FFFFFFF, 0, 100, 100, 100, 0, 16'hFFF8, 16'h7FFF, 16'h0000, 16'h0000, 1'b1);
    tbl[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    tbl[3].vld = 1'b0;
    // 4: largest unclamped value; negative channel ReLU'd
    tbl[4]  = mk(2'b00, 262136, 0, -32'sd5, 7, 0, 3, 0, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    // 5: one past max clamps; 33-bit positive p must not wrap
    tbl[5]  = mk(2'b00, 262137, 15, 32'sh7FFFFFFF, 7, 0, 32'sh7FFFFFFF, 0, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b1);
    // 6: floor rounding of negatives, exact minimum is not a clamp
    tbl[6]  = mk(2'b10, -32'sd1, -32'sd9, -32'sd262144, 0, 0, 0, 0, 16'hFFFF, 16'hFFFE, 16'h8000, 16'h0000, 1'b0);
    // 7: negative clamp
    tbl[7]  = mk(2'b10, -32'sd262145, 32'sh80000000, 7, 0, 0, 0, 0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1);
    // 8: channel sum beyond IN_W must not wrap, clamps
    tbl[8]  = mk(2'b01, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 0, 0, 0, 32'sh7FFFFFFF,
                 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1);
    // 9: conv2 negative sum -> 0; huge channels are not driven fields so no sat
    tbl[9]  = mk(2'b01, 32'sh7FFFFFFF, -32'sh7FFFFFFF, 0, 0, 0, 0, -32'sd8, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    // 10: conv1 with a huge channel sum; sum is not driven so no sat
    tbl[10] = mk(2'b00, 32'sh10000000, 32'sh10000000, 32'sh10000000, -32'sh10000000, -32'sh10000000,
                 -32'sh10000000, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    // 11: negative 33-bit p must not wrap to positive
    tbl[11] = mk(2'b00, 32'sh80000000, 0, 0, -32'sd1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    bub = tbl[3];
    va  = mk(2'b10, 8, 0, 0, 0, 0, 0, 0, 16'h0001, 16'h0, 16'h0, 16'h0, 1'b0);
    vb  = mk(2'b10, 16, 0, 0, 0, 0, 0, 0, 16'h0002, 16'h0, 16'h0, 16'h0, 1'b0);
    vc  = mk(2'b10, 24, 0, 0, 0, 0, 0, 0, 16'h0003, 16'h0, 16'h0, 16'h0, 1'b0);
    vr  = mk(2'b11, 1000, 2000, 3000, 5, 5, 5, 7, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    reset = 1'b1; out_ready = 1'b1;
    drive(bub);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_sum", out_sum, '0);
    chk("rst_sat", out_sat, 1'b0);
    chk("rst_mode_err", mode_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Back-to-back stream with mixed layers and one bubble.
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2) expect_out($sformatf("vec%0d", c - 2), tbl[c-2]);
      if (c < 12) drive(tbl[c]); else drive(bub);
    end
    chk("stream_mode_err", mode_err, 1'b0);

    // Backpressure: A, B, C with out_ready low.
    @(negedge clk); out_ready = 1'b0; drive(va);
    @(negedge clk); chk("bp_a_lat1", out_valid, 1'b0); drive(vb);
    @(negedge clk); expect_out("bp_a", va); chk("bp_full_rdy", in_ready, 1'b0); drive(vc);
    @(negedge clk); expect_out("bp_a_hold", va); chk("bp_hold_rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", in_ready, 1'b1);
    @(negedge clk); drive(bub); expect_out("bp_b", vb);
    @(negedge clk); expect_out("bp_c", vc);
    @(negedge clk); chk("bp_drain", out_valid, 1'b0);

    // Reserved mode sets the sticky error and outputs zeros.
    drive(vr);
    @(negedge clk); drive(bub); chk("rsv_err_set", mode_err, 1'b1);
    @(negedge clk); expect_out("rsv", vr);
    drive(tbl[0]);
    @(negedge clk); drive(bub);
    @(negedge clk); expect_out("rsv_next", tbl[0]); chk("rsv_err_sticky", mode_err, 1'b1);

    // Reset with two beats in flight.
    @(negedge clk); drive(tbl[0]);
    @(negedge clk); drive(tbl[2]);
    @(negedge clk); reset = 1'b1; drive(bub); chk("mid_pre_valid", out_valid, 1'b1);
    @(negedge clk); reset = 1'b0;
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_mode_err", mode_err, 1'b0);
    chk("mid_in_ready", in_ready, 1'b1);
    chk("mid_data", out_data, '0);
    drive(tbl[1]);
    @(negedge clk); drive(bub); chk("mid_lat1", out_valid, 1'b0);
    @(negedge clk); expect_out("mid_first", tbl[1]);
    @(negedge clk); chk("mid_no_ghost", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
